unisr_seq_ctrl: RTL and testbench
=================================

// Module: unisr_seq_ctrl
// PURPOSE
//   Command sequencer for the 8-bit universal shift register (UniSR).
//   Accepts one command at a time over a valid/ready handshake and drives UniSR's mode/serial/parallel inputs.
//   Supports load, clear, logical shift, rotate and arithmetic shift by 0..WIDTH positions.
//   Uses UniSR ParOut as feedback for rotate and arithmetic fill.
// PARAMETERS
//   WIDTH  8  shift register width; must match UniSR
//   AMT_W  4  shift-amount width; covers 0..WIDTH
// PORTS
//   clk        in   1      rising-edge clock shared with UniSR
//   rst_n      in   1      synchronous, active-low reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      controller idle; command accepted when valid&&ready at a clk edge
//   cmd_op     in   3      0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ROTL, 5 ROTR, 6 ASR, 7 CLEAR
//   cmd_amt    in   AMT_W  shift count for ops 2..6; ignored for 0, 1, 7
//   cmd_fill   in   1      serial fill bit for SHL/SHR
//   cmd_data   in   WIDTH  load value for LOAD
//   sr_q       in   WIDTH  UniSR ParOut feedback
//   m          out  2      UniSR mode: 0 hold, 1 shr ({sr,q[W-1:1]}), 2 shl ({q[W-2:0],sl}), 3 load
//   sl         out  1      UniSR left serial input
//   sr         out  1      UniSR right serial input
//   ParIn      out  WIDTH  UniSR parallel load value
//   busy       out  1      command in progress (EXEC or DONE)
//   done       out  1      one-cycle pulse; sr_q holds the command result during it
// BEHAVIOUR
//   Reset (rst_n low at an edge)
//     - state=IDLE, cnt=0, latched op/fill/data=0, done=0.
//     - m=0, sl=0, sr=0, ParIn=0.
//     - cmd_ready=0 while rst_n is low.
//     - Mid-command reset aborts; m=0 from the next cycle. UniSR contents are left untouched.
//   FSM: IDLE -> EXEC -> DONE -> IDLE.
//   IDLE
//     - cmd_ready=1, m=0.
//     - On accept: latch op, fill, data, and cnt = min(cmd_amt, WIDTH).
//     - Go to EXEC, or to DONE directly when the op is NOP or a shift op with cnt==0.
//   EXEC: outputs are combinational from state, latched op, and sr_q.
//     - LOAD:  m=3, ParIn=data.
//     - CLEAR: m=3, ParIn=0.
//     - SHL:   m=2, sl=fill.
//     - SHR:   m=1, sr=fill.
//     - ROTL:  m=2, sl=sr_q[W-1].
//     - ROTR:  m=1, sr=sr_q[0].
//     - ASR:   m=1, sr=sr_q[W-1].
//     - Exactly one UniSR operation per EXEC cycle; cnt decrements per shift.
//     - Leave for DONE at the edge where cnt==1, or after the single cycle for LOAD/CLEAR.
//   DONE: m=0, done=1, busy=1, cmd_ready=0. Go to IDLE at the next edge.
//   Latency
//     - Shift by n (n>=1): n EXEC cycles + 1 DONE cycle.
//     - Next accept is possible n+2 cycles after the previous accept.
//     - LOAD/CLEAR: 1+1 cycles. NOP or amt 0: DONE only.
//   Amount rules: cmd_amt>WIDTH is clamped to WIDTH. ROTx by WIDTH restores the original value.
//   Outside EXEC: m=0, sl=0, sr=0, ParIn=0 (no glitch-driven shifts).
//   cmd_valid while busy is ignored; the command is held by the requester until ready.
// TESTING
//   1) LOAD data=8'hA5 -> one EXEC with m=3, ParIn=A5; done pulses with sr_q=A5.
//   2) From 8'hA5, SHL amt=3 fill=1 -> 3 cycles m=2; done pulses with sr_q=8'h2F.
//   3) From 8'h81, ROTR amt=1 -> sr_q=8'hC0. Then ROTL amt=8 -> sr_q=8'hC0 after 8 shifts.
//   4) From 8'h90, ASR amt=2 -> sr_q=8'hE4. Then SHR amt=12 fill=0 -> clamped to 8 shifts, sr_q=8'h00.
//   5) NOP and SHL amt=0 -> done on the cycle after accept, m stays 0, sr_q unchanged.
//      cmd_valid held during busy -> no second accept until IDLE.
//   6) rst_n low mid-SHL after 2 of 5 shifts -> m=0 next cycle, cmd_ready=0 while low.
//      After release: cmd_ready=1, done never pulses for the aborted command.

Source files
------------

// File: rtl/unisr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// unisr_seq_ctrl
//   Command sequencer for an 8-bit universal shift register (UniSR).
//   One command is accepted at a time over a valid/ready handshake and is
//   turned into a sequence of UniSR mode/serial/parallel drives. Rotate and
//   arithmetic-shift fill bits come from the UniSR parallel output (sr_q), so
//   the register itself is the only copy of the data.
//
// Ports
//   clk        in   1      rising-edge clock shared with UniSR
//   rst_n      in   1      synchronous active-low reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      idle; command accepted on valid && ready at an edge
//   cmd_op     in   3      0 NOP,1 LOAD,2 SHL,3 SHR,4 ROTL,5 ROTR,6 ASR,7 CLEAR
//   cmd_amt    in   AMT_W  shift count for ops 2..6 (clamped to WIDTH)
//   cmd_fill   in   1      serial fill bit for SHL/SHR
//   cmd_data   in   WIDTH  load value for LOAD
//   sr_q       in   WIDTH  UniSR parallel output (feedback)
//   m          out  2      UniSR mode: 0 hold, 1 shr, 2 shl, 3 load
//   sl         out  1      UniSR left serial input
//   sr         out  1      UniSR right serial input
//   ParIn      out  WIDTH  UniSR parallel load value
//   busy       out  1      command in progress (EXEC or DONE)
//   done       out  1      one-cycle pulse; sr_q holds the result during it
// ---------------------------------------------------------------------------
module unisr_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] sr_q,
  output logic [1:0]       m,
  output logic             sl,
  output logic             sr,
  output logic [WIDTH-1:0] ParIn,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_SHL   = 3'd2;
  localparam logic [2:0] OP_SHR   = 3'd3;
  localparam logic [2:0] OP_ROTL  = 3'd4;
  localparam logic [2:0] OP_ROTR  = 3'd5;
  localparam logic [2:0] OP_ASR   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [1:0] M_HOLD = 2'd0;
  localparam logic [1:0] M_SHR  = 2'd1;
  localparam logic [1:0] M_SHL  = 2'd2;
  localparam logic [1:0] M_LOAD = 2'd3;

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);
  localparam logic [AMT_W-1:0] AMT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [AMT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_fill;
  logic [WIDTH-1:0] r_data;

  logic             w_accept;
  logic [AMT_W-1:0] w_amt_clamped;
  logic             w_in_is_shift;
  logic             w_op_is_single;

  // Only the end bits of the feedback matter (rotate/ASR fill); the middle
  // bits are deliberately not used.
  logic             w_unused_sr_q;
  assign w_unused_sr_q = ^sr_q[WIDTH-2:1];

  // cmd_ready is forced low while reset is asserted so no command can be
  // accepted on the reset edge.
  assign cmd_ready     = rst_n && (r_state == ST_IDLE);
  assign w_accept      = cmd_valid && cmd_ready;
  assign w_amt_clamped = (cmd_amt > AMT_MAX) ? AMT_MAX : cmd_amt;
  assign w_in_is_shift = (cmd_op >= OP_SHL) && (cmd_op <= OP_ASR);

  // LOAD and CLEAR take exactly one EXEC cycle regardless of the count.
  assign w_op_is_single = (r_op == OP_LOAD) || (r_op == OP_CLEAR);

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);

  // State and command registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_NOP;
      r_fill  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_fill <= cmd_fill;
        r_data <= cmd_data;
        r_cnt  <= w_amt_clamped;
      end else if ((r_state == ST_EXEC) && (r_cnt != AMT_ZERO)) begin
        r_cnt <= r_cnt - AMT_ONE;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if ((cmd_op == OP_NOP) || (w_in_is_shift && (w_amt_clamped == AMT_ZERO))) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        // cnt==0 can only occur here for LOAD/CLEAR; treat it as last cycle
        // too so a corrupted count can never stall the sequencer.
        if (w_op_is_single || (r_cnt <= AMT_ONE)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // UniSR drive. Everything is held at zero outside EXEC so the register only
  // ever moves during an EXEC cycle.
  always_comb begin
    m     = M_HOLD;
    sl    = 1'b0;
    sr    = 1'b0;
    ParIn = '0;
    if (r_state == ST_EXEC) begin
      case (r_op)
        OP_LOAD: begin
          m     = M_LOAD;
          ParIn = r_data;
        end
        OP_CLEAR: begin
          m     = M_LOAD;
          ParIn = '0;
        end
        OP_SHL: begin
          m  = M_SHL;
          sl = r_fill;
        end
        OP_SHR: begin
          m  = M_SHR;
          sr = r_fill;
        end
        OP_ROTL: begin
          // MSB wraps round into the LSB.
          m  = M_SHL;
          sl = sr_q[WIDTH-1];
        end
        OP_ROTR: begin
          // LSB wraps round into the MSB.
          m  = M_SHR;
          sr = sr_q[0];
        end
        OP_ASR: begin
          // Sign bit is replicated into the vacated MSB.
          m  = M_SHR;
          sr = sr_q[WIDTH-1];
        end
        default: begin
          m = M_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unisr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_unisr_seq_ctrl
//   Bench for unisr_seq_ctrl. A UniSR register model closes the feedback
//   loop; a reference model predicts each command's result arithmetically
//   and its timeline (n EXEC cycles then one DONE) from the accept cycle.
//   Directed commands carry literal result/latency expectations; a random
//   phase follows.
// ---------------------------------------------------------------------------
module tb_unisr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_amt;
  logic       cmd_fill;
  logic [7:0] cmd_data;
  logic [7:0] sr_q;
  logic [1:0] m;
  logic       sl;
  logic       sr;
  logic [7:0] ParIn;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  unisr_seq_ctrl #(.WIDTH(8), .AMT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_fill  (cmd_fill),
    .cmd_data  (cmd_data),
    .sr_q      (sr_q),
    .m         (m),
    .sl        (sl),
    .sr        (sr),
    .ParIn     (ParIn),
    .busy      (busy),
    .done      (done)
  );

  // UniSR: contents are not affected by the controller's reset.
  logic [7:0] usr_q = 8'h00;
  always @(posedge clk) begin
    case (m)
      2'd1:    usr_q <= {sr, usr_q[7:1]};
      2'd2:    usr_q <= {usr_q[6:0], sl};
      2'd3:    usr_q <= ParIn;
      default: usr_q <= usr_q;
    endcase
  end
  assign sr_q = usr_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Literal expectations attached to the next command by the stimulus.
  bit         pin_en = 1'b0;
  logic [7:0] pin_val = 8'h00;
  int         pin_lat = 0;
  int         tmo_cnt = 0;
  int         tmo_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Result and EXEC-cycle count of a command, straight from the op definitions.
  function automatic void predict(input logic [2:0] op, input logic [3:0] amt,
                                  input logic fill, input logic [7:0] data,
                                  input logic [7:0] q, output int n,
                                  output logic [7:0] res);
    int k;
    logic [15:0] t;
    logic [7:0] f;
    k = (amt > 4'd8) ? 8 : int'(amt);
    f = fill ? 8'hFF : 8'h00;
    t = 16'h0;
    n = k;
    res = q;
    case (op)
      3'd0: begin n = 0; res = q; end
      3'd1: begin n = 1; res = data; end
      3'd7: begin n = 1; res = 8'h00; end
      3'd2: begin t = {q, f} << k;          res = t[15:8]; end
      3'd3: begin t = {f, q} >> k;          res = t[7:0];  end
      3'd4: begin t = {q, q} << k;          res = t[15:8]; end
      3'd5: begin t = {q, q} >> k;          res = t[7:0];  end
      default: begin t = {{8{q[7]}}, q} >> k; res = t[7:0]; end
    endcase
  endfunction

  function automatic logic [1:0] mode_of(input logic [2:0] op);
    case (op)
      3'd1, 3'd7: mode_of = 2'd3;
      3'd2, 3'd4: mode_of = 2'd2;
      3'd3, 3'd5, 3'd6: mode_of = 2'd1;
      default: mode_of = 2'd0;
    endcase
  endfunction

  // Reference model state.
  bit         active = 1'b0;
  int         acc_c = 0;
  int         n_exec = 0;
  logic [2:0] a_op = 3'd0;
  logic       a_fill = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic [7:0] exp_res = 8'h00;
  bit         rst_prev_low = 1'b0;
  bit         a_pin_armed = 1'b0;
  logic [7:0] a_pin_val = 8'h00;
  int         a_pin_lat = 0;

  // Single compare process: all checks happen on the falling edge.
  always @(negedge clk) begin
    bit exp_ready;
    cyc++;
    exp_ready = 1'b0;
    if (tmo_cnt != tmo_seen) begin
      errors++;
      $display("FAIL handshake_timeout cyc=%0d actual=no_ready required=ready", cyc);
      tmo_seen = tmo_cnt;
    end
    if (!rst_n) begin
      chk("ready_in_reset", cmd_ready, 1'b0);
      if (rst_prev_low) begin
        chk("m_in_reset", m, 2'd0);
        chk("done_in_reset", done, 1'b0);
        chk("busy_in_reset", busy, 1'b0);
      end
      active = 1'b0;
      a_pin_armed = 1'b0;
      rst_prev_low = 1'b1;
    end else begin
      rst_prev_low = 1'b0;
      // Literal pins are measured on the DUT's own done pulse.
      if (a_pin_armed && done === 1'b1) begin
        chk("pin_result", sr_q, a_pin_val);
        chk("pin_latency", cyc - acc_c, a_pin_lat);
        a_pin_armed = 1'b0;
      end
      if (active && cyc <= acc_c + n_exec) begin
        chk("exec_m", m, mode_of(a_op));
        chk("exec_busy", busy, 1'b1);
        chk("exec_done", done, 1'b0);
        chk("exec_ready", cmd_ready, 1'b0);
        case (a_op)
          3'd1: chk("exec_parin", ParIn, a_data);
          3'd7: chk("exec_parin", ParIn, 8'h00);
          3'd2: chk("exec_sl", sl, a_fill);
          3'd3: chk("exec_sr", sr, a_fill);
          3'd4: chk("exec_sl", sl, sr_q[7]);
          3'd5: chk("exec_sr", sr, sr_q[0]);
          default: chk("exec_sr", sr, sr_q[7]);
        endcase
      end else if (active && cyc == acc_c + n_exec + 1) begin
        chk("done_pulse", done, 1'b1);
        chk("done_m", m, 2'd0);
        chk("done_busy", busy, 1'b1);
        chk("done_ready", cmd_ready, 1'b0);
        chk("result", sr_q, exp_res);
        $display("txn op=%0d n=%0d result=%02h expected=%02h", a_op, n_exec, sr_q, exp_res);
        active = 1'b0;
      end else begin
        chk("idle_ready", cmd_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_m", m, 2'd0);
        chk("idle_serial", {sl, sr}, 2'b00);
        chk("idle_parin", ParIn, 8'h00);
        exp_ready = 1'b1;
      end
      if (exp_ready && cmd_valid) begin
        predict(cmd_op, cmd_amt, cmd_fill, cmd_data, sr_q, n_exec, exp_res);
        acc_c = cyc;
        a_op = cmd_op;
        a_fill = cmd_fill;
        a_data = cmd_data;
        active = 1'b1;
        a_pin_armed = pin_en;
        a_pin_val = pin_val;
        a_pin_lat = pin_lat;
      end
    end
  end

  // Holds the command until it is accepted; returns just after the accept edge.
  task automatic send(input logic [2:0] op, input logic [3:0] amt, input logic fill,
                      input logic [7:0] data, input bit pe, input logic [7:0] pv,
                      input int pl);
    int guard;
    pin_en = pe;
    pin_val = pv;
    pin_lat = pl;
    cmd_op = op;
    cmd_amt = amt;
    cmd_fill = fill;
    cmd_data = data;
    cmd_valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready === 1'b1 && rst_n === 1'b1) break;
      guard++;
      if (guard > 60) begin
        tmo_cnt++;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    pin_en = 1'b0;
    cmd_op = 3'($urandom);
    cmd_amt = 4'($urandom);
  endtask

  task automatic pulse_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_amt = 4'd0;
    cmd_fill = 1'b0;
    cmd_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed commands with literal results and accept-to-done latencies.
    send(3'd1, 4'd0,  1'b0, 8'hA5, 1'b1, 8'hA5, 2);
    send(3'd2, 4'd3,  1'b1, 8'h00, 1'b1, 8'h2F, 4);
    send(3'd1, 4'd0,  1'b0, 8'h81, 1'b1, 8'h81, 2);
    send(3'd5, 4'd1,  1'b0, 8'h00, 1'b1, 8'hC0, 2);
    send(3'd4, 4'd8,  1'b0, 8'h00, 1'b1, 8'hC0, 9);
    send(3'd1, 4'd0,  1'b0, 8'h90, 1'b1, 8'h90, 2);
    send(3'd6, 4'd2,  1'b0, 8'h00, 1'b1, 8'hE4, 3);
    send(3'd3, 4'd12, 1'b0, 8'h00, 1'b1, 8'h00, 9);
    send(3'd1, 4'd0,  1'b0, 8'h3C, 1'b1, 8'h3C, 2);
    send(3'd0, 4'd5,  1'b1, 8'hFF, 1'b1, 8'h3C, 1);
    send(3'd2, 4'd0,  1'b1, 8'h00, 1'b1, 8'h3C, 1);
    send(3'd7, 4'd9,  1'b1, 8'hFF, 1'b1, 8'h00, 2);

    // Abort a 5-shift SHL after two shifts.
    send(3'd1, 4'd0,  1'b0, 8'h5A, 1'b0, 8'h00, 0);
    send(3'd2, 4'd5,  1'b1, 8'h00, 1'b0, 8'h00, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    pulse_reset(3);
    repeat (2) @(posedge clk);
    #1;

    // Random commands; valid is raised while the previous one is still busy.
    for (int i = 0; i < 200; i++) begin
      send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom),
           8'($urandom), 1'b0, 8'h00, 0);
      if ($urandom_range(0, 24) == 0) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
        pulse_reset($urandom_range(1, 3));
      end else if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 12)) @(posedge clk);
        #1;
      end
    end

    repeat (15) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

endmodule
